pid_velocity_controller: RTL and testbench
==========================================

Name: pid_velocity_controller

Overview:
Parametrised, pipelined velocity-form PID controller for the laser control loop. It is the successor of the fixed-gain 9-bit PI block. Each valid error sample produces one corrected drive sample. Gains are runtime ports in signed fixed point, the output is saturated with anti-windup, and the derivative term can be compiled in or out. It sits between the error-measurement block and the laser drive DAC interface and accepts one sample per clock.

Parameters:
DATA_W, 9, width of error_in and signal_out (signed two's complement)
COEF_W, 12, width of kp/ki/kd (signed two's complement)
FRAC_W, 8, fractional bits of gains; a gain of 1.0 equals 2^FRAC_W
OUT_MAX, 2^(DATA_W-1)-1, upper saturation limit (signed); must satisfy OUT_MIN < OUT_MAX
OUT_MIN, -2^(DATA_W-1), lower saturation limit (signed)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
clear  input  1  synchronous loop reset: zeroes history and accumulator, drops in-flight samples
in_valid  input  1  error_in holds a new sample this cycle
error_in  input  DATA_W  signed error sample
kp  input  COEF_W  signed proportional gain, Q(FRAC_W)
ki  input  COEF_W  signed integral gain, Q(FRAC_W)
kd  input  COEF_W  signed derivative gain, Q(FRAC_W)
out_valid  output  1  signal_out holds a new sample this cycle
signal_out  output  DATA_W  signed saturated drive value
sat_hi  output  1  last output clamped to OUT_MAX
sat_lo  output  1  last output clamped to OUT_MIN

Behaviour:
- Control law, per accepted sample n:
  - u[n] = sat( u[n-1] + ((kp*(e[n]-e[n-1]) + ki*e[n] + kd*(e[n]-2e[n-1]+e[n-2])) >>> FRAC_W) ).
  - u[n-1] is the previous saturated output. This is the anti-windup rule: no hidden unsaturated accumulator.
- Stage 0 (cycle of in_valid):
  - Register e[n], d1 = e[n]-e[n-1] (DATA_W+1 bits) and d2 = e[n]-2e[n-1]+e[n-2] (DATA_W+2 bits).
  - Shift the history registers e[n-1] and e[n-2].
  - Stage 0 is the only place history advances.
- Stage 1:
  - Form the three products at full width.
  - kp/ki/kd are sampled in this stage, in the same cycle the sample occupies it. A gain change takes effect on the next sample in flight.
- Stage 2:
  - Sum the products at full width (no intermediate truncation).
  - Arithmetic right shift by FRAC_W (floor toward -inf).
  - Add u[n-1] in a width of at least DATA_W+COEF_W+4, clamp to [OUT_MIN, OUT_MAX], register into signal_out and u[n-1].
- Latency: out_valid is asserted exactly 3 cycles after in_valid. Throughput is one sample per cycle; back-to-back samples are legal. Gaps in in_valid leave all state untouched.
- Saturation flags:
  - sat_hi is 1 when the stage-2 sum > OUT_MAX; sat_lo is 1 when the sum < OUT_MIN; at most one is set.
  - Both flags update only with out_valid and hold otherwise.
- signal_out holds its value between valid outputs.
- Reset (at any time, including mid-pipeline):
  - Next cycle: out_valid=0, signal_out=0, sat_hi=0, sat_lo=0.
  - History, accumulator and pipeline valid bits are all 0.
  - In-flight samples are discarded and never emerge.
- clear: same effect as reset on internal state and valid bits. signal_out, sat_hi and sat_lo also go to 0. clear has priority over in_valid in the same cycle, and that sample is dropped.
- Out-of-range parameters (OUT_MIN >= OUT_MAX) are a configuration error. Flag with a simulation-time check.

Optional Feature:
- Macro PID_DERIV_EN.
- Defined: derivative path present as above.
- Undefined:
  - No kd multiplier and no e[n-2] register.
  - The kd port is still present but ignored; the block is a PI controller.
  - Latency and all other behaviour are unchanged.

Test Plan:
- Pure P: DATA_W=9, FRAC_W=8, kp=256, ki=kd=0. Errors 10,20,-5 back-to-back -> outputs 10,20,-5 at in_valid+3 cycles each, flags 0.
- Pure I: ki=64, kp=kd=0, error 8 for 4 samples with 1-cycle gaps -> outputs 2,4,6,8; out_valid pattern mirrors in_valid delayed 3.
- Saturation/anti-windup: ki=256, error 100 x4 -> 100,200,255(sat_hi),255(sat_hi). Then error -50 -> 205, sat_hi=0.
- Derivative: kd=256, kp=ki=0, errors 0,10,10,10 -> 0,10,0,0 with PID_DERIV_EN; 0,0,0,0 without.
- Rounding: kp=128, single error -1 from zero history -> output -1 (floor). Then error -1 again -> -1 (d1=0).
- Reset/clear mid-operation: 3 samples in flight, assert reset (then separately clear) for 1 cycle -> no out_valid for those samples. Next sample with kp=256, error 7 -> output 7.

Source files
------------

// File: rtl/pid_velocity_controller.sv
// Three-stage velocity-form PID controller with saturating, anti-windup output.
// Define PID_DERIV_EN to build the derivative (kd) path; otherwise it is a PI controller.
module pid_velocity_controller #(
  parameter int DATA_W  = 9,
  parameter int COEF_W  = 12,
  parameter int FRAC_W  = 8,
  parameter int OUT_MAX = 2**(DATA_W-1) - 1,
  parameter int OUT_MIN = -(2**(DATA_W-1))
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] error_in,
  input  logic signed [COEF_W-1:0] kp,
  input  logic signed [COEF_W-1:0] ki,
  input  logic signed [COEF_W-1:0] kd,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] signal_out,
  output logic                     sat_hi,
  output logic                     sat_lo
);

  localparam int D1_W  = DATA_W + 1;
  localparam int PP_W  = COEF_W + D1_W;
  localparam int PI_W  = COEF_W + DATA_W;
  localparam int ACC_W = DATA_W + COEF_W + 4;

  localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_A = ACC_W'(OUT_MIN);

  logic flush;
  assign flush = reset | clear;

  logic signed [DATA_W-1:0] e_prev1;
  logic                     s0_valid;
  logic signed [DATA_W-1:0] s0_e;
  logic signed [D1_W-1:0]   s0_d1;

  logic                     s1_valid;
  logic signed [PP_W-1:0]   s1_p;
  logic signed [PI_W-1:0]   s1_i;

  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  acc;

  // Stage 0: capture the sample and its differences; history only moves here.
  always_ff @(posedge clk) begin
    if (flush) begin
      e_prev1  <= '0;
      s0_valid <= 1'b0;
      s0_e     <= '0;
      s0_d1    <= '0;
    end else if (in_valid) begin
      s0_valid <= 1'b1;
      s0_e     <= error_in;
      s0_d1    <= D1_W'(error_in) - D1_W'(e_prev1);
      e_prev1  <= error_in;
    end else begin
      s0_valid <= 1'b0;
    end
  end

  // Stage 1: full-width products; gains are sampled while the sample sits here.
  always_ff @(posedge clk) begin
    if (flush) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_i     <= '0;
    end else begin
      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_p <= PP_W'(kp) * PP_W'(s0_d1);
        s1_i <= PI_W'(ki) * PI_W'(s0_e);
      end
    end
  end

`ifdef PID_DERIV_EN
  localparam int D2_W = DATA_W + 2;
  localparam int PD_W = COEF_W + D2_W;

  logic signed [DATA_W-1:0] e_prev2;
  logic signed [D2_W-1:0]   s0_d2;
  logic signed [PD_W-1:0]   s1_d;

  always_ff @(posedge clk) begin
    if (flush) begin
      e_prev2 <= '0;
      s0_d2   <= '0;
    end else if (in_valid) begin
      s0_d2   <= D2_W'(error_in) - (D2_W'(e_prev1) <<< 1) + D2_W'(e_prev2);
      e_prev2 <= e_prev1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      s1_d <= '0;
    end else if (s0_valid) begin
      s1_d <= PD_W'(kd) * PD_W'(s0_d2);
    end
  end
`else
  logic unused_kd;
  assign unused_kd = ^kd;
`endif

  // Stage 2 datapath: the increment is added to the last saturated output,
  // so no unsaturated accumulator can wind up.
  always_comb begin
    sum = ACC_W'(s1_p) + ACC_W'(s1_i);
`ifdef PID_DERIV_EN
    sum = sum + ACC_W'(s1_d);
`endif
    shifted = sum >>> FRAC_W;
    acc     = shifted + ACC_W'(signal_out);
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      out_valid  <= 1'b0;
      signal_out <= '0;
      sat_hi     <= 1'b0;
      sat_lo     <= 1'b0;
    end else if (s1_valid) begin
      out_valid <= 1'b1;
      sat_hi    <= (acc > MAX_A);
      sat_lo    <= (acc < MIN_A);
      if (acc > MAX_A) begin
        signal_out <= DATA_W'(MAX_A);
      end else if (acc < MIN_A) begin
        signal_out <= DATA_W'(MIN_A);
      end else begin
        signal_out <= acc[DATA_W-1:0];
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

  // A clamp window that is empty or inverted is a configuration error.
  always @(posedge clk) begin
    if (reset) begin
      assert (OUT_MIN < OUT_MAX)
        else $error("pid_velocity_controller: OUT_MIN (%0d) must be below OUT_MAX (%0d)", OUT_MIN, OUT_MAX);
    end
  end

endmodule

// File: tb/tb_pid_velocity_controller.sv
// Randomised self-checking bench for pid_velocity_controller against a per-sample
// timeline model; define PID_DERIV_EN here too when the DUT is built with it.
module tb_pid_velocity_controller;

  localparam int DATA_W = 9;
  localparam int COEF_W = 12;
  localparam int FRAC_W = 8;
  localparam int OMAX   = 255;
  localparam int OMIN   = -256;
  localparam int N      = 1100;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     clear = 1'b0;
  logic                     in_valid = 1'b0;
  logic signed [DATA_W-1:0] error_in = '0;
  logic signed [COEF_W-1:0] kp = '0;
  logic signed [COEF_W-1:0] ki = '0;
  logic signed [COEF_W-1:0] kd = '0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] signal_out;
  logic                     sat_hi;
  logic                     sat_lo;

  pid_velocity_controller #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .error_in(error_in), .kp(kp), .ki(ki), .kd(kd),
    .out_valid(out_valid), .signal_out(signal_out),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 clk = ~clk;

  bit st_iv[N];
  bit st_rs[N];
  bit st_cl[N];
  int st_e[N];
  int st_kp[N];
  int st_ki[N];
  int st_kd[N];

  bit ex_v[N+1];
  int ex_o[N+1];
  bit ex_hi[N+1];
  bit ex_lo[N+1];

  bit lit_has[N+4];
  bit lit_v[N+4];
  int lit_o[N+4];
  bit lit_hi[N+4];
  bit lit_lo[N+4];

  bit ok[N];
  int se[N];
  int sd1[N];
  int sd2[N];

  int cur;
  int gkp, gki, gkd;
  int vectors;
  int miscompares;
  int cyc;
  bit running;

  task automatic put(input bit iv, input int e, input bit rs, input bit cl);
    st_iv[cur] = iv; st_e[cur] = e; st_rs[cur] = rs; st_cl[cur] = cl;
    st_kp[cur] = gkp; st_ki[cur] = gki; st_kd[cur] = gkd;
    cur++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic set_lit(input int c, input bit v, input int o, input bit hi, input bit lo);
    lit_has[c] = 1'b1; lit_v[c] = v; lit_o[c] = o; lit_hi[c] = hi; lit_lo[c] = lo;
  endtask

  // A sample whose output must appear three cycles later with the given value.
  task automatic sample(input int e, input int o, input bit hi, input bit lo);
    set_lit(cur + 3, 1'b1, o, hi, lo);
    put(1'b1, e, 1'b0, 1'b0);
  endtask

  task automatic build_stimulus;
    int r;
    cur = 0; gkp = 0; gki = 0; gkd = 0;
    put(1'b0, 0, 1'b1, 1'b0);
    put(1'b1, 33, 1'b1, 1'b0);
    // pure P
    gkp = 256;
    sample(10, 10, 0, 0); sample(20, 20, 0, 0); sample(-5, -5, 0, 0); idle(4);
    // pure I with gaps
    gkp = 0; gki = 64;
    put(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin sample(8, 2 * (i + 1), 0, 0); idle(1); end
    idle(4);
    // saturation and anti-windup
    gki = 256;
    put(1'b0, 0, 1'b0, 1'b1);
    sample(100, 100, 0, 0); sample(100, 200, 0, 0); sample(100, 255, 1, 0);
    sample(100, 255, 1, 0); sample(-50, 205, 0, 0); idle(4);
    // derivative
    gki = 0; gkd = 256;
    put(1'b0, 0, 1'b0, 1'b1);
`ifdef PID_DERIV_EN
    sample(0, 0, 0, 0); sample(10, 10, 0, 0); sample(10, 0, 0, 0); sample(10, 0, 0, 0);
`else
    sample(0, 0, 0, 0); sample(10, 0, 0, 0); sample(10, 0, 0, 0); sample(10, 0, 0, 0);
`endif
    idle(4);
    // floor rounding
    gkd = 0; gkp = 128;
    put(1'b0, 0, 1'b0, 1'b1);
    sample(-1, -1, 0, 0); sample(-1, -1, 0, 0); idle(4);
    // reset with samples in flight
    gkp = 256;
    put(1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) set_lit(cur + 3 + i, 1'b0, 0, 0, 0);
    put(1'b1, 30, 1'b0, 1'b0); put(1'b1, 40, 1'b0, 1'b0); put(1'b1, 50, 1'b1, 1'b0);
    idle(3); sample(7, 7, 0, 0); idle(4);
    // clear with samples in flight; history and output were 7 before the clear
    for (int i = 0; i < 3; i++) set_lit(cur + 3 + i, 1'b0, 0, 0, 0);
    put(1'b1, 30, 1'b0, 1'b0); put(1'b1, 40, 1'b0, 1'b0); put(1'b1, 50, 1'b0, 1'b1);
    idle(3); sample(7, 7, 0, 0); idle(4);
    // randomised traffic with gains changing every cycle
    while (cur < N - 8) begin
      r = int'($urandom_range(0, 3));
      gkp = (r == 0) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 767)) - 256;
      gki = (r == 1) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 511)) - 128;
      gkd = (r == 2) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom_range(0, 511)) - 256;
      put($urandom_range(0, 9) < 7,
          ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 511)) - 256 : int'($urandom_range(0, 40)) - 20,
          $urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0);
    end
    while (cur < N) idle(1);
  endtask

  // Timeline model: a sample accepted in cycle s (no reset/clear in s, s+1, s+2)
  // emerges in cycle s+3 using the gains present in cycle s+1 and the previous output.
  task automatic build_model;
    int h1, h2, term, acc, s;
    bit r;
    h1 = 0; h2 = 0;
    ex_v[0] = 1'b0; ex_o[0] = 0; ex_hi[0] = 1'b0; ex_lo[0] = 1'b0;
    for (int c = 0; c < N; c++) begin
      r = st_rs[c] | st_cl[c];
      ok[c] = 1'b0;
      if (st_iv[c] && !r) begin
        ok[c]  = 1'b1;
        se[c]  = st_e[c];
        sd1[c] = st_e[c] - h1;
        sd2[c] = st_e[c] - 2 * h1 + h2;
        h2 = h1;
        h1 = st_e[c];
      end
      if (r) begin h1 = 0; h2 = 0; end
      s = c - 2;
      if (r) begin
        ex_v[c+1] = 1'b0; ex_o[c+1] = 0; ex_hi[c+1] = 1'b0; ex_lo[c+1] = 1'b0;
      end else if (s >= 0 && ok[s] && !(st_rs[s+1] | st_cl[s+1])) begin
        term = st_kp[s+1] * sd1[s] + st_ki[s+1] * se[s];
`ifdef PID_DERIV_EN
        term = term + st_kd[s+1] * sd2[s];
`endif
        acc = ex_o[c] + (term >>> FRAC_W);
        ex_v[c+1]  = 1'b1;
        ex_hi[c+1] = acc > OMAX;
        ex_lo[c+1] = acc < OMIN;
        ex_o[c+1]  = (acc > OMAX) ? OMAX : ((acc < OMIN) ? OMIN : acc);
      end else begin
        ex_v[c+1] = 1'b0; ex_o[c+1] = ex_o[c]; ex_hi[c+1] = ex_hi[c]; ex_lo[c+1] = ex_lo[c];
      end
    end
  endtask

  task automatic check_model_literals;
    for (int c = 1; c < N; c++) begin
      if (lit_has[c]) begin
        vectors++;
        if (ex_v[c] != lit_v[c] || ex_o[c] != lit_o[c] || ex_hi[c] != lit_hi[c] || ex_lo[c] != lit_lo[c]) begin
          miscompares++;
          $display("[TB] FAIL model_lit cycle %0d: model v=%0b o=%0d hi=%0b lo=%0b, required v=%0b o=%0d hi=%0b lo=%0b",
                   c, ex_v[c], ex_o[c], ex_hi[c], ex_lo[c], lit_v[c], lit_o[c], lit_hi[c], lit_lo[c]);
        end
      end
    end
  endtask

  task automatic apply_stimulus(input int c);
    reset    = st_rs[c];
    clear    = st_cl[c];
    in_valid = st_iv[c];
    error_in = DATA_W'(st_e[c]);
    kp       = COEF_W'(st_kp[c]);
    ki       = COEF_W'(st_ki[c]);
    kd       = COEF_W'(st_kd[c]);
  endtask

  task automatic check_bit(input string name, input int c, input logic got, input bit req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %0b, required %0b", name, c, got, req);
    end
  endtask

  task automatic check_word(input string name, input int c, input int req);
    logic signed [DATA_W-1:0] want;
    want = DATA_W'(req);
    vectors++;
    if (signal_out !== want) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %0d (%b), required %0d", name, c, signal_out, signal_out, req);
    end
  endtask

  task automatic check_output(input int c);
    check_bit("out_valid", c, out_valid, ex_v[c]);
    check_word("signal_out", c, ex_o[c]);
    check_bit("sat_hi", c, sat_hi, ex_hi[c]);
    check_bit("sat_lo", c, sat_lo, ex_lo[c]);
    if (lit_has[c]) begin
      check_bit("lit_out_valid", c, out_valid, lit_v[c]);
      check_word("lit_signal_out", c, lit_o[c]);
      check_bit("lit_sat_hi", c, sat_hi, lit_hi[c]);
      check_bit("lit_sat_lo", c, sat_lo, lit_lo[c]);
    end
  endtask

  // Outputs are compared at the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (running && cyc >= 1) check_output(cyc);
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; running = 1'b0;
    build_stimulus();
    build_model();
    check_model_literals();
    for (int c = 0; c < N; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      apply_stimulus(c);
      running = 1'b1;
    end
    @(posedge clk);
    #1;
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
